// File: rtl/cbfp_denorm_pkg.sv
// cbfp_denorm_pkg: shared CBFP constants and types (package cbfp_pkg).
package cbfp_pkg;
  localparam int ARRAY_SIZE = 16;
  localparam int ROWS = 4;
  localparam int DIN_W = 11;
  localparam int CNT_W = 5;
  localparam int ROW_W = $clog2(ROWS);
  typedef logic signed [DIN_W-1:0] mant_t;
  typedef mant_t [ARRAY_SIZE-1:0] row_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic cnt_t cmin(input cnt_t a, input cnt_t b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/cbfp_denorm_if.sv
// cbfp_denorm_if: row-in / aligned-row-out bus of the CBFP denormaliser.
interface cbfp_denorm_if;
  import cbfp_pkg::*;
  logic valid_in;
  row_t din_re;
  row_t din_im;
  cnt_t cnt_re;
  cnt_t cnt_im;
  logic valid_out;
  row_t dout_re;
  row_t dout_im;
  cnt_t dout_exp;
  logic dout_last;
  modport master (
    output valid_in, din_re, din_im, cnt_re, cnt_im,
    input valid_out, dout_re, dout_im, dout_exp, dout_last
  );
  modport slave (
    input valid_in, din_re, din_im, cnt_re, cnt_im,
    output valid_out, dout_re, dout_im, dout_exp, dout_last
  );
endinterface

// File: rtl/cbfp_denorm_align_lane.sv
// cbfp_align_lane: per-lane arithmetic right shift; rounds half-up when CBFP_DENORM_ROUND_EN is defined.
module cbfp_align_lane
  import cbfp_pkg::*;
(
  input  mant_t din_i,
  input  cnt_t  sh_i,
  output mant_t dout_o
);
`ifdef CBFP_DENORM_ROUND_EN
  localparam logic signed [DIN_W:0] MAX = (DIN_W+1)'((1 << (DIN_W-1)) - 1);
  logic [DIN_W:0] rnd;
  logic signed [DIN_W:0] sum;
  logic signed [DIN_W:0] shr;
  always_comb begin
    rnd = (DIN_W+1)'(1) << (sh_i - cnt_t'(1));
    sum = {din_i[DIN_W-1], din_i} + rnd;
    shr = sum >>> sh_i;
    dout_o = sh_i == '0 ? din_i : sh_i >= cnt_t'(DIN_W) ? '0 : shr > MAX ? MAX[DIN_W-1:0] : shr[DIN_W-1:0];
  end
`else
  mant_t shr;
  always_comb begin
    shr = din_i >>> sh_i;
    dout_o = sh_i >= cnt_t'(DIN_W) ? {DIN_W{din_i[DIN_W-1]}} : shr;
  end
`endif
endmodule

// File: rtl/cbfp_denorm.sv
// cbfp_denorm: realigns each 4-row CBFP block to its minimum exponent via ping-pong banks.
// Optional macro CBFP_DENORM_ROUND_EN adds half-up rounding and one output pipeline stage.
module cbfp_denorm
  import cbfp_pkg::*;
(
  input logic clk,
  input logic rstn,
  cbfp_denorm_if.slave bus
);
  row_t mem_re_q [2][ROWS];
  row_t mem_im_q [2][ROWS];
  cnt_t cre_q [2][ROWS];
  cnt_t cim_q [2][ROWS];
  cnt_t exp_q [2];
  logic [1:0] full_q;
  logic wr_bank_q, rd_bank_q, ovr_q;
  logic [ROW_W-1:0] wr_row_q, rd_row_q;
  cnt_t min_q, min_d, sh_re, sh_im;
  state_t state_q;
  logic wr_ok, wr_last, rd_last, emit;
  row_t al_re, al_im;
  logic v1_q, l1_q;
  cnt_t e1_q;
  row_t re1_q, im1_q;
  always_comb begin
    wr_ok = bus.valid_in && !(wr_row_q == '0 && &full_q);
    wr_last = wr_row_q == ROW_W'(ROWS-1);
    rd_last = rd_row_q == ROW_W'(ROWS-1);
    min_d = wr_row_q == '0 ? cmin(bus.cnt_re, bus.cnt_im) : cmin(min_q, cmin(bus.cnt_re, bus.cnt_im));
    emit = state_q == EMIT || full_q[rd_bank_q];
    sh_re = cre_q[rd_bank_q][rd_row_q] - exp_q[rd_bank_q];
    sh_im = cim_q[rd_bank_q][rd_row_q] - exp_q[rd_bank_q];
  end
  for (genvar l = 0; l < ARRAY_SIZE; l++) begin : g_lane
    cbfp_align_lane u_re (.din_i(mem_re_q[rd_bank_q][rd_row_q][l]), .sh_i(sh_re), .dout_o(al_re[l]));
    cbfp_align_lane u_im (.din_i(mem_im_q[rd_bank_q][rd_row_q][l]), .sh_i(sh_im), .dout_o(al_im[l]));
  end
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_re_q[wr_bank_q][wr_row_q] <= bus.din_re;
      mem_im_q[wr_bank_q][wr_row_q] <= bus.din_im;
      cre_q[wr_bank_q][wr_row_q] <= bus.cnt_re;
      cim_q[wr_bank_q][wr_row_q] <= bus.cnt_im;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_row_q <= '0;
      wr_bank_q <= 1'b0;
      rd_row_q <= '0;
      rd_bank_q <= 1'b0;
      full_q <= '0;
      min_q <= '0;
      exp_q <= '{default: '0};
      ovr_q <= 1'b0;
      state_q <= IDLE;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      e1_q <= '0;
      re1_q <= '0;
      im1_q <= '0;
    end else begin
      if (bus.valid_in && !wr_ok) ovr_q <= 1'b1;
      if (wr_ok) begin
        min_q <= min_d;
        wr_row_q <= wr_last ? '0 : wr_row_q + ROW_W'(1);
        if (wr_last) begin
          exp_q[wr_bank_q] <= min_d;
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q <= ~wr_bank_q;
        end
      end
      v1_q <= emit;
      l1_q <= emit && rd_last;
      // A bank that fills on this same edge is picked up from IDLE next cycle, so no bubble appears
      if (emit) begin
        re1_q <= al_re;
        im1_q <= al_im;
        e1_q <= exp_q[rd_bank_q];
        if (rd_last) begin
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q <= ~rd_bank_q;
          rd_row_q <= '0;
          state_q <= full_q[~rd_bank_q] ? EMIT : IDLE;
        end else begin
          rd_row_q <= rd_row_q + ROW_W'(1);
          state_q <= EMIT;
        end
      end
    end
  end
  always_ff @(posedge clk) assert (rstn || !ovr_q);
`ifdef CBFP_DENORM_ROUND_EN
  logic v2_q, l2_q;
  cnt_t e2_q;
  row_t re2_q, im2_q;
  always_ff @(posedge clk) begin
    if (rstn) begin
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      e2_q <= '0;
      re2_q <= '0;
      im2_q <= '0;
    end else begin
      v2_q <= v1_q;
      l2_q <= l1_q;
      e2_q <= e1_q;
      re2_q <= re1_q;
      im2_q <= im1_q;
    end
  end
  assign bus.valid_out = v2_q;
  assign bus.dout_last = l2_q;
  assign bus.dout_exp = e2_q;
  assign bus.dout_re = re2_q;
  assign bus.dout_im = im2_q;
`else
  assign bus.valid_out = v1_q;
  assign bus.dout_last = l1_q;
  assign bus.dout_exp = e1_q;
  assign bus.dout_re = re1_q;
  assign bus.dout_im = im1_q;
`endif
endmodule

// File: tb/tb_cbfp_denorm.sv
// tb_cbfp_denorm: directed bench for cbfp_denorm; honours CBFP_DENORM_ROUND_EN.
module tb_cbfp_denorm;
  import cbfp_pkg::*;
`ifdef CBFP_DENORM_ROUND_EN
  localparam int LAT = 2;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit RND = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn;
  int checks = 0;
  int errors = 0;
  int i_re[12], i_im[12], i_cr[12], i_ci[12], e_re[12], e_im[12], e_x[12];
  cbfp_denorm_if bus ();
  cbfp_denorm dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  function automatic row_t rep(input int v);
    row_t r;
    for (int l = 0; l < ARRAY_SIZE; l++) r[l] = v[DIN_W-1:0];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_row(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_row(input int j, input int dre, input int dim, input int cr, input int ci,
                         input int ere, input int eim, input int ex);
    i_re[j] = dre; i_im[j] = dim; i_cr[j] = cr; i_ci[j] = ci;
    e_re[j] = ere; e_im[j] = eim; e_x[j] = ex;
  endtask
  task automatic drive(input int j);
    bus.valid_in = 1'b1;
    bus.din_re = rep(i_re[j]);
    bus.din_im = rep(i_im[j]);
    bus.cnt_re = cnt_t'(i_cr[j]);
    bus.cnt_im = cnt_t'(i_ci[j]);
  endtask
  task automatic test1_rows();
    set_row(0, 256, 256, 3, 4, 128, 64, 2);
    set_row(1, 256, 256, 5, 5, 32, 32, 2);
    set_row(2, 256, 256, 2, 6, 256, 16, 2);
    set_row(3, 256, 256, 7, 3, 8, 128, 2);
  endtask
  // Row j is driven every gap+1 cycles; each block's rows emerge LAT cycles after its last row is accepted.
  task automatic run(input string name, input int n, input int gap);
    int idx[64];
    int j, t_end;
    foreach (idx[t]) idx[t] = -1;
    for (int q = 0; q < n; q++) idx[(4*(q/4)+3)*(gap+1) + 1 + LAT + q%4] = q;
    t_end = (n-1)*(gap+1) + LAT + 6;
    for (int t = 0; t <= t_end; t++) begin
      j = idx[t];
      if (j >= 0) begin
        chk($sformatf("%s r%0d valid", name, j), 32'(bus.valid_out), 1);
        chk($sformatf("%s r%0d exp", name, j), 32'(bus.dout_exp), 32'(e_x[j]));
        chk($sformatf("%s r%0d last", name, j), 32'(bus.dout_last), 32'(j % 4 == 3));
        chk_row($sformatf("%s r%0d re", name, j), bus.dout_re, rep(e_re[j]));
        chk_row($sformatf("%s r%0d im", name, j), bus.dout_im, rep(e_im[j]));
      end else begin
        chk($sformatf("%s t%0d idle valid", name, t), 32'(bus.valid_out), 0);
        chk($sformatf("%s t%0d idle last", name, t), 32'(bus.dout_last), 0);
      end
      if (t % (gap+1) == 0 && t/(gap+1) < n) drive(t/(gap+1));
      else bus.valid_in = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, " valid"}, 32'(bus.valid_out), 0);
    chk({name, " last"}, 32'(bus.dout_last), 0);
    chk({name, " exp"}, 32'(bus.dout_exp), 0);
    chk_row({name, " re"}, bus.dout_re, rep(0));
    chk_row({name, " im"}, bus.dout_im, rep(0));
  endtask
  initial begin
    rstn = 1'b1;
    bus.valid_in = 1'b0;
    bus.din_re = '0;
    bus.din_im = '0;
    bus.cnt_re = '0;
    bus.cnt_im = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b0;
    @(negedge clk);
    test1_rows();
    run("single", 4, 0);
    set_row(0, -1024, -1024, 0, 12, -1024, RND ? 0 : -1, 0);
    for (int q = 1; q < 4; q++) set_row(q, -1024, -1024, 0, 0, -1024, -1024, 0);
    run("negshift", 4, 0);
    set_row(0, 3, 3, 1, 1, RND ? 2 : 1, RND ? 2 : 1, 0);
    set_row(1, -1, -3, 1, 1, RND ? 0 : -1, RND ? -1 : -2, 0);
    set_row(2, 5, -5, 0, 0, 5, -5, 0);
    set_row(3, 5, -5, 0, 0, 5, -5, 0);
    run("round", 4, 0);
    for (int q = 0; q < 4; q++) set_row(q, 64, 64, 4, 4, 64, 64, 4);
    set_row(4, 64, 64, 1, 2, 64, 32, 1);
    for (int q = 5; q < 8; q++) set_row(q, 64, 64, 3, 3, 16, 16, 1);
    for (int q = 8; q < 11; q++) set_row(q, 1023, 1023, 2, 2, 1023, 1023, 2);
    set_row(11, 1023, -1024, 10, 10, RND ? 4 : 3, -4, 2);
    run("b2b", 12, 0);
    test1_rows();
    run("gapped", 4, 2);
    set_row(0, 100, 100, 0, 0, 100, 100, 0);
    set_row(1, 100, 100, 0, 0, 100, 100, 0);
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk_zero("midrst a");
    @(negedge clk);
    chk_zero("midrst b");
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("postrst");
    test1_rows();
    run("fresh", 4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Inverse end of the FFT CBFP normaliser.
- The normaliser emits 11-bit mantissas for each 16-lane row, plus a 5-bit leading-zero count (exponent) per row, separately for re and im.
- This block re-aligns each 4-row block (64 samples) to one common block exponent: every row is arithmetically right-shifted by (row_cnt − block_min_cnt).
- It emits the aligned rows with the block exponent, so downstream stages and the index-sum logic see one scale per block.

Parameters:
- ARRAY_SIZE, 16, lanes per row
- ROWS, 4, rows per CBFP block
- DIN_W, 11, mantissa width (input and output)
- CNT_W, 5, exponent/zero-count width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-high (1 = reset)
- valid_in  in  1  one row present this cycle
- din_re  in  [ARRAY_SIZE][DIN_W] signed  real mantissas
- din_im  in  [ARRAY_SIZE][DIN_W] signed  imag mantissas
- cnt_re  in  CNT_W  zero count of this row, real
- cnt_im  in  CNT_W  zero count of this row, imag
- valid_out  out  1  aligned row valid
- dout_re  out  [ARRAY_SIZE][DIN_W] signed  aligned real row
- dout_im  out  [ARRAY_SIZE][DIN_W] signed  aligned imag row
- dout_exp  out  CNT_W  common block exponent (min count of block)
- dout_last  out  1  high with 4th output row of a block

Behaviour:
- Reset (rstn=1 at clk edge):
  - valid_out, dout_last = 0; dout_re, dout_im = 0; dout_exp = 0.
  - Write row counter = 0, write bank = 0, output FSM = IDLE, both bank-full flags cleared.
  - Reset mid-block discards the partial block and any pending output.
- Input side:
  - Rows are accepted only on valid_in=1; gaps are allowed anywhere, and the row counter holds during gaps.
  - Row r (0..3) is written into the current write bank together with cnt_re and cnt_im.
  - A running minimum over all 2·ROWS counts is kept; it seeds from min(cnt_re, cnt_im) at r=0.
  - On r=3: latch min into that bank's exponent register, set the bank-full flag, toggle the write bank, and wrap the counter to 0.
- Storage: ping-pong, 2 banks × ROWS × ARRAY_SIZE × 2 × DIN_W, plus per-row counts.
- Output FSM states:
  - IDLE: any bank full → EMIT, row 0, from the oldest full bank.
  - EMIT: emit one row per cycle with valid_out=1, rows 0..3 consecutive, no gaps; dout_last=1 on row 3.
  - After row 3: clear that bank's full flag. If the other bank is full, continue straight into its row 0 (no bubble); else go to IDLE.
- Latency: first output row is registered 1 cycle after the edge that accepts input row 3. Output rate equals the maximum input rate, so continuous input never overflows.
- Overrun (both banks full and a new row 0 arrives): the write is dropped and a sticky internal overrun flag is set. This is unreachable under rate rules; verification asserts it never fires.
- Arithmetic, per lane and per component:
  - sh = row_cnt − block_min, always ≥0, CNT_W bits.
  - out = din >>> sh (arithmetic).
  - If sh ≥ DIN_W, out = {DIN_W{sign}}, i.e. 0 or −1.
  - No saturation is needed; magnitude never grows.
- dout_exp is constant for all 4 rows of a block.
- Simultaneous last-row write and emit-from-same-bank cannot occur; the full flag gates the read.

Optional Feature:
- Macro CBFP_DENORM_ROUND_EN.
- Defined: round half-up before the shift, out = (din + (1<<(sh−1))) >>> sh for 1 ≤ sh < DIN_W.
  - Positive overflow (result would exceed 2^(DIN_W−1)−1) saturates to max.
  - sh=0 passes through; sh ≥ DIN_W gives 0. Rounded-off −0.5 goes to 0.
  - Adds one pipeline register: latency +1 cycle; valid_out and dout_last delay by the same amount.
- Undefined: truncation as above.

Decomposition:
- Shared package cbfp_pkg: ARRAY_SIZE, ROWS, DIN_W, CNT_W constants; typedefs for the mantissa row type and the count type.
- One sub-module cbfp_align_lane: combinational per-lane shift/round (din, sh → out), instantiated 2·ARRAY_SIZE times.

Test Plan:
- Single block: all mantissas 0x100; counts (re,im) = (3,4),(5,5),(2,6),(7,3). Required: dout_exp=2; row0 = 0x080/0x040; row2 = 0x100/0x010; dout_last only on row 3; first valid_out 1 cycle after the 4th valid_in.
- Negative and large shift: din=−1024, counts 0 and 12 in one block. Required: shift-12 row outputs −1 (0 with ROUND_EN); shift-0 row outputs −1024 unchanged.
- Back-to-back 3 blocks, valid_in held high for 12 cycles. Required: valid_out high for 12 consecutive cycles, correct exponent per block, dout_last every 4th cycle.
- Gapped input: rows with 2-cycle gaps between each. Required: single block output, same data as the gap-free case; no spurious valid_out.
- Reset asserted after 2 rows, then a full fresh block. Required: only the fresh block appears; all outputs 0 during and after reset until its emission.
- ROUND_EN: din=0x003, sh=1. Required: 0x002 with the macro, 0x001 without; latency +1 confirmed.
